// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: issue bus between the sequencer and the control unit / ALU stage.
// Signals:
//   opcode[2:0], a[7:0], b[7:0] : instruction fields driven by the sequencer
//   issue_valid                 : fields are valid (held stable until accepted)
//   issue_ready                 : downstream stage accepts the current instruction
//   save                        : one-cycle strobe, result register captures the ALU result
// Modports: master = sequencer side, slave = ALU / control-unit side.
interface instr_sequencer_if;
   logic [2:0] opcode;
   logic [7:0] a;
   logic [7:0] b;
   logic       issue_valid;
   logic       issue_ready;
   logic       save;
   modport master (output opcode, a, b, issue_valid, save, input issue_ready);
   modport slave  (input opcode, a, b, issue_valid, save, output issue_ready);
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: writable program memory plus program counter that issues one instruction
// at a time to the ALU stage over a valid/ready handshake.
// Ports:
//   clk          : system clock
//   reset        : synchronous active-low reset (program memory is not cleared)
//   start_i      : begin execution at address 0 (honoured in IDLE/HALT only)
//   prog_we_i    : program memory write enable (accepted in IDLE/HALT only)
//   prog_addr_i  : program memory write address
//   prog_data_i  : instruction word, [19]=halt [18:16]=opcode [15:8]=a [7:0]=b
//   bus          : issue bus (opcode/a/b/issue_valid/save out, issue_ready in)
//   busy_o       : high in FETCH or ISSUE
//   done_o       : one-cycle pulse on entry to HALT (or on each wrap in loop mode)
//   pc_o         : current program counter
//   loop_count_o : wraps taken, saturating at 255 (only when SEQ_LOOP_EN is defined)
// Optional feature: define SEQ_LOOP_EN to wrap back to address 0 instead of halting.
module instr_sequencer #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic                  prog_we_i,
   input  logic [ADDR_W-1:0]     prog_addr_i,
   input  logic [19:0]           prog_data_i,
   instr_sequencer_if.master     bus,
`ifdef SEQ_LOOP_EN
   output logic [7:0]            loop_count_o,
`endif
   output logic                  busy_o,
   output logic                  done_o,
   output logic [ADDR_W-1:0]     pc_o
);
   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;
   localparam logic [ADDR_W-1:0] last_pc = ADDR_W'(DEPTH - 1);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [2:0]        opcode_q, opcode_d;
   logic [7:0]        a_q, a_d, b_q, b_d;
   logic              save_q, save_d, done_q, done_d;
   logic [19:0]       mem [DEPTH];
   logic [19:0]       word;
   logic              prog_ok;
`ifdef SEQ_LOOP_EN
   logic [7:0]        loop_q, loop_d;
   logic              wrap;
`endif
   assign word    = mem[pc_q];
   assign prog_ok = (state_q == IDLE) || (state_q == HALT);
   // Memory has no reset so the program survives a reset pulse.
   always_ff @(posedge clk) begin
      if (prog_we_i && prog_ok)
         mem[prog_addr_i] <= prog_data_i;
   end
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      opcode_d = opcode_q;
      a_d      = a_q;
      b_d      = b_q;
      save_d   = 1'b0;
      done_d   = 1'b0;
`ifdef SEQ_LOOP_EN
      wrap     = 1'b0;
`endif
      case (state_q)
         IDLE, HALT: begin
            if (start_i) begin
               state_d = FETCH;
               pc_d    = '0;
            end
         end
         FETCH: begin
            {opcode_d, a_d, b_d} = word[18:0];
            if (word[19]) begin
               done_d = 1'b1;
`ifdef SEQ_LOOP_EN
               wrap    = 1'b1;
               pc_d    = '0;
               state_d = FETCH;
`else
               state_d = HALT;
`endif
            end else begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.issue_ready) begin
               save_d = 1'b1;
               if (pc_q == last_pc) begin
                  done_d = 1'b1;
`ifdef SEQ_LOOP_EN
                  wrap    = 1'b1;
                  pc_d    = '0;
                  state_d = FETCH;
`else
                  state_d = HALT;
`endif
               end else begin
                  pc_d    = pc_q + 1'b1;
                  state_d = FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef SEQ_LOOP_EN
      loop_d = (wrap && loop_q != 8'hFF) ? loop_q + 8'd1 : loop_q;
`endif
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         opcode_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         save_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SEQ_LOOP_EN
         loop_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         opcode_q <= opcode_d;
         a_q      <= a_d;
         b_q      <= b_d;
         save_q   <= save_d;
         done_q   <= done_d;
`ifdef SEQ_LOOP_EN
         loop_q   <= loop_d;
`endif
      end
   end
   assign bus.opcode      = opcode_q;
   assign bus.a           = a_q;
   assign bus.b           = b_q;
   assign bus.issue_valid = (state_q == ISSUE);
   assign bus.save        = save_q;
   assign busy_o          = (state_q == FETCH) || (state_q == ISSUE);
   assign done_o          = done_q;
   assign pc_o            = pc_q;
`ifdef SEQ_LOOP_EN
   assign loop_count_o    = loop_q;
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench for instr_sequencer (expected instructions queued at start,
// popped on each handshake).
module tb_instr_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        prog_we = 1'b0;
   logic [3:0]  prog_addr = '0;
   logic [19:0] prog_data = '0;
   logic        busy_w, done_w;
   logic [3:0]  pc_w;
   int          n_chk = 0;
   int          n_err = 0;
   int          save_cnt = 0;
   int          s0 = 0;
   int          exp_saves = 0;
   logic [3:0]  exp_pc = '0;
   logic [18:0] q [$];
   logic [19:0] model [16];
   instr_sequencer_if bus ();
   instr_sequencer #(.DEPTH(16), .ADDR_W(4)) dut (
      .clk(clk), .reset(reset), .start_i(start), .prog_we_i(prog_we),
      .prog_addr_i(prog_addr), .prog_data_i(prog_data), .bus(bus),
      .busy_o(busy_w), .done_o(done_w), .pc_o(pc_w)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (reset && bus.issue_valid && bus.issue_ready) begin
         check("sb_avail", 32'(q.size() != 0), 1);
         if (q.size() != 0) check("instr", {bus.opcode, bus.a, bus.b}, q.pop_front());
      end
   end
   always @(negedge clk) if (bus.save === 1'b1) save_cnt++;
   task automatic load(input logic [3:0] addr, input logic [19:0] data);
      prog_we = 1'b1; prog_addr = addr; prog_data = data;
      model[addr] = data;
      @(posedge clk); #1;
      prog_we = 1'b0;
   endtask
   task automatic start_prog();
      exp_saves = 0;
      exp_pc = 4'd15;
      for (int i = 0; i < 16; i++) begin
         if (model[i][19]) begin
            exp_pc = 4'(i);
            break;
         end
         q.push_back(model[i][18:0]);
         exp_saves++;
      end
      s0 = save_cnt;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask
   task automatic wait_done();
      int k = 0;
      while (done_w !== 1'b1 && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      check("done_seen", 32'(done_w), 1);
      check("pc_halt", 32'(pc_w), 32'(exp_pc));
      @(posedge clk); #1;
      check("done_pulse", 32'(done_w), 0);
      check("pc_hold", 32'(pc_w), 32'(exp_pc));
      check("busy_halt", 32'(busy_w), 0);
      check("saves", 32'(save_cnt - s0), 32'(exp_saves));
      check("sb_drained", 32'(q.size()), 0);
   endtask
   initial begin
      for (int i = 0; i < 16; i++) model[i] = '0;
      bus.issue_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      check("rst_pc", 32'(pc_w), 0);
      check("rst_valid", 32'(bus.issue_valid), 0);
      check("rst_busy", 32'(busy_w), 0);
      check("rst_done", 32'(done_w), 0);
      check("rst_save", 32'(bus.save), 0);
      // basic program: one op then halt
      load(4'd0, {1'b0, 3'b000, 8'd5, 8'd3});
      load(4'd1, {1'b1, 3'b000, 8'd0, 8'd0});
      start_prog();
      check("lat_fetch", 32'(bus.issue_valid), 0);
      @(posedge clk); #1;
      check("lat_issue", 32'(bus.issue_valid), 1);
      check("lat_fields", {bus.opcode, bus.a, bus.b}, {3'b000, 8'd5, 8'd3});
      @(posedge clk); #1;
      check("save_strobe", 32'(bus.save), 1);
      check("valid_drop", 32'(bus.issue_valid), 0);
      wait_done();
      // backpressure
      load(4'd0, {1'b0, 3'b101, 8'h12, 8'h34});
      bus.issue_ready = 1'b0;
      start_prog();
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(bus.issue_valid), 1);
         check("bp_fields", {bus.opcode, bus.a, bus.b}, {3'b101, 8'h12, 8'h34});
         check("bp_nosave", 32'(bus.save), 0);
         @(posedge clk); #1;
      end
      bus.issue_ready = 1'b1;
      wait_done();
      // end of memory: 16 non-halt words
      for (int i = 0; i < 16; i++) load(4'(i), {1'b0, 3'(i), 8'(i * 3 + 1), ~8'(i)});
      start_prog();
      wait_done();
      // write while busy is ignored (a halt at 3 would stop the run early)
      start_prog();
      @(posedge clk); #1;
      prog_we = 1'b1; prog_addr = 4'd3; prog_data = {1'b1, 3'b111, 8'hAA, 8'hBB};
      @(posedge clk); #1;
      prog_we = 1'b0;
      wait_done();
      // write in HALT takes effect
      load(4'd3, {1'b1, 3'b111, 8'hAA, 8'hBB});
      start_prog();
      wait_done();
      // reset while issuing
      bus.issue_ready = 1'b0;
      start_prog();
      @(posedge clk); #1;
      check("mid_valid", 32'(bus.issue_valid), 1);
      reset = 1'b0;
      bus.issue_ready = 1'b1;
      @(posedge clk); #1;
      q.delete();
      check("mr_valid", 32'(bus.issue_valid), 0);
      check("mr_busy", 32'(busy_w), 0);
      check("mr_pc", 32'(pc_w), 0);
      check("mr_save", 32'(bus.save), 0);
      check("mr_fields", {bus.opcode, bus.a, bus.b}, 0);
      reset = 1'b1;
      s0 = save_cnt;
      @(posedge clk); #1;
      check("mr_nosave", 32'(save_cnt - s0), 0);
      start_prog();
      wait_done();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
